// File: rtl/fir_mac_sequencer.sv
// Sequencer for a single-multiplier FIR: writes each accepted sample into a circular
// sample RAM, walks TAPS multiply-accumulates against a coefficient ROM, emits a saturated Q15 result.
module fir_mac_sequencer #(
    parameter int TAPS   = 31,
    parameter int ADDR_W = 5,
    parameter int ACC_W  = 40
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic signed [15:0]       in_sample_i,
    output logic                     smp_we_o,
    output logic        [ADDR_W-1:0] smp_waddr_o,
    output logic signed [15:0]       smp_wdata_o,
    output logic        [ADDR_W-1:0] smp_raddr_o,
    input  logic signed [15:0]       smp_rdata_i,
    output logic        [ADDR_W-1:0] coef_raddr_o,
    input  logic signed [15:0]       coef_rdata_i,
    output logic                     out_valid_o,
    output logic signed [15:0]       out_sample_o,
    output logic                     out_sat_o,
    output logic                     busy_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(TAPS - 1);

    state_t                    state_q;
    logic        [ADDR_W-1:0]  wr_ptr_q;
    logic        [ADDR_W-1:0]  k_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic                      in_ready_q;
    logic                      busy_q;
    logic                      smp_we_q;
    logic        [ADDR_W-1:0]  smp_waddr_q;
    logic signed [15:0]        smp_wdata_q;
    logic        [ADDR_W-1:0]  smp_raddr_q;
    logic        [ADDR_W-1:0]  coef_raddr_q;
    logic                      out_valid_q;
    logic signed [15:0]        out_sample_q;
    logic                      out_sat_q;

    logic signed [31:0]        prod_d;
    logic signed [ACC_W-1:0]   prod_ext_d;

    // Clip acc>>>15 to Q15; bit 16 of the result flags that clipping happened.
    function automatic logic [16:0] sat_q15(input logic signed [ACC_W-1:0] a);
        logic [16:0] r;
        if ((&a[ACC_W-1:30]) || (~|a[ACC_W-1:30])) begin
            r = {1'b0, a[30:15]};
        end else if (a[ACC_W-1]) begin
            r = {1'b1, 16'h8000};
        end else begin
            r = {1'b1, 16'h7FFF};
        end
        return r;
    endfunction

    assign prod_d     = smp_rdata_i * coef_rdata_i;
    assign prod_ext_d = {{(ACC_W-32){prod_d[31]}}, prod_d};

    // Sequencer state, datapath registers and registered outputs.
    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            smp_we_q     <= 1'b0;
            smp_waddr_q  <= '0;
            smp_wdata_q  <= 16'sd0;
            smp_raddr_q  <= '0;
            coef_raddr_q <= '0;
            out_valid_q  <= 1'b0;
            out_sample_q <= 16'sd0;
            out_sat_q    <= 1'b0;
        end else begin
            smp_we_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        smp_we_q    <= 1'b1;
                        smp_waddr_q <= wr_ptr_q;
                        smp_wdata_q <= in_sample_i;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= WRITE;
                    end
                end
                WRITE: begin
                    acc_q        <= '0;
                    k_q          <= '0;
                    smp_raddr_q  <= wr_ptr_q;
                    coef_raddr_q <= '0;
                    state_q      <= MAC;
                end
                MAC: begin
                    // Read data trails the address by one cycle, so tap 0 has nothing to add yet.
                    if (k_q != '0) begin
                        acc_q <= acc_q + prod_ext_d;
                    end
                    if (k_q == LAST_K) begin
                        state_q <= DRAIN;
                    end else begin
                        k_q          <= k_q + ONE_A;
                        smp_raddr_q  <= wr_ptr_q - (k_q + ONE_A);
                        coef_raddr_q <= k_q + ONE_A;
                    end
                end
                DRAIN: begin
                    acc_q   <= acc_q + prod_ext_d;
                    state_q <= DONE;
                end
                DONE: begin
                    out_valid_q               <= 1'b1;
                    {out_sat_q, out_sample_q} <= sat_q15(acc_q);
                    wr_ptr_q                  <= wr_ptr_q + ONE_A;
                    in_ready_q                <= 1'b1;
                    busy_q                    <= 1'b0;
                    state_q                   <= IDLE;
                end
                default: begin
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o   = in_ready_q;
    assign busy_o       = busy_q;
    assign smp_we_o     = smp_we_q;
    assign smp_waddr_o  = smp_waddr_q;
    assign smp_wdata_o  = smp_wdata_q;
    assign smp_raddr_o  = smp_raddr_q;
    assign coef_raddr_o = coef_raddr_q;
    assign out_valid_o  = out_valid_q;
    assign out_sample_o = out_sample_q;
    assign out_sat_o    = out_sat_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: emulates the sample RAM / coefficient ROM and
// compares every cycle against a direct convolution model of the filter.
module tb_fir_mac_sequencer;

    localparam int TAPS   = 31;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic                     clock;
    logic                     reset_n;
    logic                     in_valid;
    logic                     in_ready_o;
    logic signed [15:0]       in_sample;
    logic                     smp_we_o;
    logic        [ADDR_W-1:0] smp_waddr_o;
    logic signed [15:0]       smp_wdata_o;
    logic        [ADDR_W-1:0] smp_raddr_o;
    logic signed [15:0]       smp_rdata;
    logic        [ADDR_W-1:0] coef_raddr_o;
    logic signed [15:0]       coef_rdata;
    logic                     out_valid_o;
    logic signed [15:0]       out_sample_o;
    logic                     out_sat_o;
    logic                     busy_o;

    fir_mac_sequencer #(.TAPS(TAPS), .ADDR_W(ADDR_W), .ACC_W(40)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready_o),
        .in_sample_i  (in_sample),
        .smp_we_o     (smp_we_o),
        .smp_waddr_o  (smp_waddr_o),
        .smp_wdata_o  (smp_wdata_o),
        .smp_raddr_o  (smp_raddr_o),
        .smp_rdata_i  (smp_rdata),
        .coef_raddr_o (coef_raddr_o),
        .coef_rdata_i (coef_rdata),
        .out_valid_o  (out_valid_o),
        .out_sample_o (out_sample_o),
        .out_sat_o    (out_sat_o),
        .busy_o       (busy_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic signed [15:0] ram [DEPTH];
    logic signed [15:0] rom [DEPTH];
    logic signed [15:0] model_mem [DEPTH];
    logic               clr_req;

    int imp_tab [TAPS] = '{-120, 756, -340, -1011, 410, 1200, -600, -2100, 800, 3600,
                           -900, -5200, 1500, 9800, 20500, 29240, 20500, 9800, 1500, -5200,
                           -900, 3600, 800, -2100, -600, 1200, 410, -1011, -340, 756, -120};

    int     vectors = 0;
    int     miscompares = 0;
    int     cyc = 0;
    bit     pend_valid = 1'b0;
    int     pend_a, pend_ptr, model_ptr;
    longint pend_exp, pend_sat, sum, q;
    bit     exp_ov;
    int     k;

    longint out_log [$];
    longint sat_log [$];
    int     acc_log [$];
    int     waddr_log [$];

    // Synchronous sample RAM and coefficient ROM, one cycle read latency.
    always @(posedge clock) begin
        if (clr_req) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= 16'sd0;
        end else if (smp_we_o) begin
            ram[smp_waddr_o] <= smp_wdata_o;
        end
        smp_rdata  <= ram[smp_raddr_o];
        coef_rdata <= rom[coef_raddr_o];
    end

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model and per-cycle compare; expectations derive from the accepted-sample history only.
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (clr_req) begin
                for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'sd0;
            end
            if (reset_n) begin
                pend_valid = 1'b0;
                model_ptr  = 0;
                check("rst_in_ready", in_ready_o, 1);
                check("rst_busy", busy_o, 0);
                check("rst_out_valid", out_valid_o, 0);
                check("rst_smp_we", smp_we_o, 0);
                check("rst_out_sat", out_sat_o, 0);
            end else begin
                exp_ov = pend_valid && (cyc == pend_a + TAPS + 3);
                check("out_valid", out_valid_o, exp_ov);
                if (exp_ov) begin
                    check("out_sample", out_sample_o, pend_exp);
                    check("out_sat", out_sat_o, pend_sat);
                    out_log.push_back(out_sample_o);
                    sat_log.push_back(out_sat_o);
                    pend_valid = 1'b0;
                end
                check("in_ready", in_ready_o, !pend_valid);
                check("busy", busy_o, pend_valid);
                if (pend_valid && cyc == pend_a) begin
                    check("smp_we", smp_we_o, 1);
                    check("smp_waddr", smp_waddr_o, pend_ptr);
                    waddr_log.push_back(smp_waddr_o);
                end else begin
                    check("smp_we_idle", smp_we_o, 0);
                end
                if (pend_valid && cyc >= pend_a + 1 && cyc <= pend_a + TAPS) begin
                    k = cyc - pend_a - 1;
                    check("smp_raddr", smp_raddr_o, (pend_ptr - k) & (DEPTH - 1));
                    check("coef_raddr", coef_raddr_o, k);
                end
                if (in_valid && in_ready_o) begin
                    model_mem[model_ptr] = in_sample;
                    sum = 0;
                    for (int n = 0; n < TAPS; n++)
                        sum += longint'(rom[n]) * longint'(model_mem[(model_ptr - n) & (DEPTH - 1)]);
                    q = sum >>> 15;
                    if (q > 32767) begin
                        pend_exp = 32767; pend_sat = 1;
                    end else if (q < -32768) begin
                        pend_exp = -32768; pend_sat = 1;
                    end else begin
                        pend_exp = q; pend_sat = 0;
                    end
                    pend_valid = 1'b1;
                    pend_a     = cyc + 1;
                    pend_ptr   = model_ptr;
                    model_ptr  = (model_ptr + 1) & (DEPTH - 1);
                    acc_log.push_back(cyc + 1);
                end
            end
        end
    end

    task automatic send(input logic signed [15:0] v, input bit keep);
        int n;
        n = 0;
        in_sample = v;
        in_valid  = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (!in_ready_o && n < 200);
        if (!in_ready_o) check("accept_timeout", 0, 1);
        @(posedge clock);
        #2;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (pend_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (pend_valid) check("idle_timeout", 0, 1);
        @(posedge clock);
        #2;
    endtask

    task automatic clear_mem();
        clr_req = 1'b1;
        @(posedge clock);
        #2;
        clr_req = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b1;
        clr_req = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic set_rom_impulse();
        for (int i = 0; i < DEPTH; i++) rom[i] = (i < TAPS) ? 16'(imp_tab[i]) : 16'sd0;
    endtask

    task automatic set_rom_const(input logic signed [15:0] v);
        for (int i = 0; i < DEPTH; i++) rom[i] = v;
    endtask

    initial begin
        reset_n   = 1'b1;
        clr_req   = 1'b1;
        in_valid  = 1'b0;
        in_sample = 16'sd0;
        set_rom_impulse();
        @(posedge clock);
        #2;
        do_reset();

        // Impulse response: output n reproduces (32767*c[n])>>>15.
        out_log.delete();
        send(16'sh7FFF, 1'b0);
        for (int i = 0; i < 30; i++) send(16'sd0, 1'b0);
        wait_idle();
        check("impulse_count", out_log.size(), 31);
        if (out_log.size() == 31) begin
            check("impulse_n1", out_log[1], 755);
            check("impulse_n3", out_log[3], -1011);
            check("impulse_n15", out_log[15], 29239);
            check("impulse_n0", out_log[0], -120);
        end

        // in_valid held high: one acceptance every 35 cycles, one output each.
        out_log.delete();
        acc_log.delete();
        for (int i = 0; i < 5; i++) send(16'(i * 3000 - 7000), 1'b1);
        in_valid = 1'b0;
        wait_idle();
        check("hold_accepts", acc_log.size(), 5);
        check("hold_outputs", out_log.size(), 5);
        for (int i = 1; i < acc_log.size(); i++)
            check("accept_period", acc_log[i] - acc_log[i-1], 35);

        // Saturation in both directions.
        set_rom_const(16'sh7FFF);
        clear_mem();
        out_log.delete();
        sat_log.delete();
        repeat (31) send(16'sh7FFF, 1'b0);
        wait_idle();
        check("sat_pos_count", out_log.size(), 31);
        if (out_log.size() == 31) begin
            check("sat_first", out_log[0], 32766);
            check("sat_first_flag", sat_log[0], 0);
            check("sat_pos", out_log[30], 32767);
            check("sat_pos_flag", sat_log[30], 1);
        end
        out_log.delete();
        sat_log.delete();
        repeat (31) send(16'sh8000, 1'b0);
        wait_idle();
        check("sat_neg_count", out_log.size(), 31);
        if (out_log.size() == 31) begin
            check("sat_neg", out_log[30], -32768);
            check("sat_neg_flag", sat_log[30], 1);
        end

        // Pointer wrap: 40 samples from a fresh reset.
        set_rom_impulse();
        do_reset();
        waddr_log.delete();
        for (int i = 0; i < 40; i++) send(16'(i), 1'b0);
        wait_idle();
        check("wrap_count", waddr_log.size(), 40);
        if (waddr_log.size() == 40) begin
            check("wrap_waddr31", waddr_log[31], 31);
            check("wrap_waddr32", waddr_log[32], 0);
            check("wrap_waddr39", waddr_log[39], 7);
        end

        // Reset while MAC is at k=10 aborts the sample.
        out_log.delete();
        send(16'sd555, 1'b0);
        repeat (11) @(posedge clock);
        #2;
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b0;
        repeat (40) @(posedge clock);
        #2;
        check("abort_no_output", out_log.size(), 0);
        check("abort_in_ready", in_ready_o, 1);
        check("abort_busy", busy_o, 0);
        waddr_log.delete();
        send(16'sd777, 1'b0);
        wait_idle();
        check("abort_next_waddr", (waddr_log.size() > 0) ? waddr_log[0] : -1, 0);

        // DC gain with 1/32 coefficients.
        set_rom_const(16'sd1024);
        out_log.delete();
        repeat (33) send(16'sd1000, 1'b0);
        wait_idle();
        check("dc_count", out_log.size(), 33);
        if (out_log.size() == 33) begin
            check("dc_fill", out_log[30], 968);
            check("dc_steady", out_log[32], 968);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Control block for a time-multiplexed, single-multiplier FIR filter. It accepts one 16-bit Q15 sample per valid/ready handshake and writes it into an external circular sample RAM. It then steps through TAPS multiply-accumulate cycles against an external coefficient ROM and emits one saturated Q15 result per input sample. It replaces the fully parallel tap array wherever multiplier count matters more than throughput.

Parameters:
TAPS, 31, number of filter taps; legal range 2..2^ADDR_W.
ADDR_W, 5, address width of the sample RAM and the coefficient ROM; RAM depth is 2^ADDR_W.
ACC_W, 40, accumulator width; must be at least 32+ceil(log2(TAPS)).

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous reset, active-high; clock clock.
in_valid  in  1  input sample valid.
in_ready  out  1  block can accept a sample.
in_sample  in  16  signed Q15 input sample.
smp_we  out  1  sample RAM write enable.
smp_waddr  out  ADDR_W  sample RAM write address.
smp_wdata  out  16  sample RAM write data.
smp_raddr  out  ADDR_W  sample RAM read address; synchronous RAM, data valid 1 cycle later.
smp_rdata  in  16  signed sample RAM read data.
coef_raddr  out  ADDR_W  coefficient ROM read address; synchronous ROM, 1-cycle latency.
coef_rdata  in  16  signed Q15 coefficient.
out_valid  out  1  one-cycle pulse; out_sample is valid.
out_sample  out  16  signed Q15 filter output.
out_sat  out  1  pulses with out_valid when the result was clipped.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, reset_n=1): state=IDLE, wr_ptr=0, k=0, acc=0. All outputs are 0 except in_ready=1. Sample RAM contents are not cleared by this block.
- Reset asserted mid-operation aborts the computation immediately. No out_valid is produced for the aborted sample.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_sample and go to WRITE. in_ready is 0 in all other states. in_valid held high while busy is ignored, not lost; the sample is accepted on the next return to IDLE.
  - WRITE (1 cycle): smp_we=1, smp_waddr=wr_ptr, smp_wdata=latched sample. Clear acc=0, set k=0. Go to MAC.
  - MAC (TAPS cycles, k=0..TAPS-1): smp_raddr=(wr_ptr-k) mod 2^ADDR_W and coef_raddr=k.
    - From the second MAC cycle onward, acc += sign-extended(smp_rdata*coef_rdata). The product is 32-bit signed.
    - After k=TAPS-1, go to DRAIN.
  - DRAIN (1 cycle): accumulate the last product. Go to DONE.
  - DONE (1 cycle): out_valid=1. out_sample = acc>>>15 (arithmetic), saturated to [-32768, 32767]; out_sat=1 if clipped. wr_ptr increments modulo 2^ADDR_W. Go to IDLE.
- Latency: with the handshake at edge 0, out_valid is high in the cycle after edge TAPS+3. Minimum sample period is TAPS+4 cycles (35 at defaults).
- Boundary conditions:
  - The newest sample is read at k=0. The RAM write in WRITE completes before the first MAC read.
  - wr_ptr wraps from 2^ADDR_W-1 to 0, and read addresses wrap the same way.
  - Unwritten RAM locations at start-up are the system's responsibility; the bench preloads zeros.
- smp_raddr/coef_raddr hold their last value outside MAC. smp_we is 0 outside WRITE.
- No intermediate saturation: the accumulator is wide enough that it cannot wrap for any TAPS ≤ 2^ADDR_W.

Test Plan:
- Impulse: ROM = fixed 31-tap table (c1=756, c15=29240, ...), RAM zeroed. Feed 0x7FFF, then 30 zeros -> outputs n=0..30 equal (32767*c[n])>>>15, e.g. n=15 gives 29239, n=1 gives 755, n=3 gives -1011.
- Handshake: in_valid held high continuously -> in_ready high once every 35 cycles; exactly one out_valid per accepted sample; no sample dropped or duplicated; out_valid 35 cycles after each acceptance.
- Saturation: all coefficients 32767, all samples 32767 -> out_sample=32767, out_sat=1. All samples -32768 with coefficients 32767 -> out_sample=-32768, out_sat=1.
- Wrap-around: feed 40 samples with value = index -> smp_waddr sequences 0..31,0..7. Reads for the 33rd sample (wr_ptr=0) go 0,31,30,...; outputs match a golden model.
- Reset mid-MAC: assert reset_n in MAC at k=10 -> out_valid never pulses; after release in_ready=1, busy=0, the next input writes at address 0.
- DC gain: all coefficients 1024 (1/32 in Q15), constant input 1000 after fill -> steady output (31*1000*1024)>>>15 = 968.
